// File: rtl/lighthouse_sweep_sequencer.sv
// Lighthouse v1 pulse sequencer: timestamps envelope pulses, classifies them
// by width, decodes sync codes and reports sweep centre times relative to the
// last non-skip sync.
//
// state  | meaning
// IDLE   | no valid reference sync; sweeps are ignored
// ARMED  | reference sync held; waiting for one sweep or the timeout
// DECODE | iteratively converting a sync width into its 3-bit code
module lighthouse_sweep_sequencer #(
    parameter int WIDTH         = 20,
    parameter int SYNC_MIN      = 1500,
    parameter int SWEEP_MIN     = 8,
    parameter int SYNC_BASE     = 3000,
    parameter int SYNC_STEP     = 500,
    parameter int SWEEP_TIMEOUT = 400000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             envelope,
    output logic             sync_valid,
    output logic             sync_skip,
    output logic             sync_data,
    output logic             sync_axis,
    output logic             sweep_valid,
    output logic             sweep_axis,
    output logic [WIDTH-1:0] sweep_time,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, ARMED, DECODE} state_t;

    localparam logic [WIDTH-1:0] SYNC_MIN_W  = WIDTH'(SYNC_MIN);
    localparam logic [WIDTH-1:0] SWEEP_MIN_W = WIDTH'(SWEEP_MIN);
    localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(SYNC_STEP);
    localparam logic [WIDTH-1:0] TIMEOUT_W   = WIDTH'(SWEEP_TIMEOUT);
    // Widths below half a step under the base all round down to code 0.
    localparam logic [WIDTH-1:0] DEC_THRESH  = WIDTH'(SYNC_BASE - SYNC_STEP / 2);

    state_t           state;
    state_t           prev_state;
    logic             env_s1;
    logic             env_s2;
    logic             env_d;
    logic [WIDTH-1:0] now;
    logic [WIDTH-1:0] rise_stamp;
    logic [WIDTH-1:0] sync_stamp;
    logic [WIDTH-1:0] cand_stamp;
    logic [WIDTH-1:0] cand_w;
    logic [WIDTH-1:0] rem;
    logic [2:0]       code;
    logic             dec_first;
    logic             ref_axis;

    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] width;
    logic [WIDTH-1:0] elapsed;
    logic             is_glitch;
    logic             is_sync;
    logic             timed_out;
    logic             dec_done;
    logic [2:0]       dec_code;

    // Two-flop synchronizer followed by the edge register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            env_s1 <= 1'b0;
            env_s2 <= 1'b0;
            env_d  <= 1'b0;
        end else begin
            env_s1 <= envelope;
            env_s2 <= env_s1;
            env_d  <= env_s2;
        end
    end

    assign rise      = env_s2 & ~env_d;
    assign fall      = ~env_s2 & env_d;
    assign width     = now - rise_stamp;
    assign elapsed   = now - sync_stamp;
    assign is_glitch = (width < SWEEP_MIN_W);
    assign is_sync   = (width >= SYNC_MIN_W);
    assign timed_out = (elapsed >= TIMEOUT_W);

    // Decide whether the current DECODE cycle terminates and with which code.
    always_comb begin
        dec_done = 1'b0;
        dec_code = code;
        if (dec_first) begin
            if (cand_w < DEC_THRESH) begin
                dec_done = 1'b1;
                dec_code = 3'd0;
            end
        end else if (!((rem >= STEP_W) && (code != 3'd7))) begin
            dec_done = 1'b1;
        end
    end

    // Timestamp counter, pulse classification and sequencing FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prev_state  <= IDLE;
            now         <= '0;
            rise_stamp  <= '0;
            sync_stamp  <= '0;
            cand_stamp  <= '0;
            cand_w      <= '0;
            rem         <= '0;
            code        <= 3'd0;
            dec_first   <= 1'b0;
            ref_axis    <= 1'b0;
            sync_valid  <= 1'b0;
            sync_skip   <= 1'b0;
            sync_data   <= 1'b0;
            sync_axis   <= 1'b0;
            sweep_valid <= 1'b0;
            sweep_axis  <= 1'b0;
            sweep_time  <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            now         <= now + 1'b1;
            sync_valid  <= 1'b0;
            sweep_valid <= 1'b0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;

            if (rise) begin
                rise_stamp <= now;
            end

            case (state)
                IDLE: begin
                    if (fall && is_sync) begin
                        cand_stamp <= rise_stamp;
                        cand_w     <= width;
                        prev_state <= IDLE;
                        dec_first  <= 1'b1;
                        state      <= DECODE;
                    end
                end
                ARMED: begin
                    if (fall && is_sync) begin
                        cand_stamp <= rise_stamp;
                        cand_w     <= width;
                        // An expired reference must not be revived by a skip sync.
                        prev_state <= timed_out ? IDLE : ARMED;
                        timeout    <= timed_out;
                        dec_first  <= 1'b1;
                        state      <= DECODE;
                    end else if (fall && !is_glitch) begin
                        sweep_time  <= rise_stamp - sync_stamp + (width >> 1);
                        sweep_axis  <= ref_axis;
                        sweep_valid <= 1'b1;
                        state       <= IDLE;
                    end else if (timed_out) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DECODE: begin
                    if (fall) begin
                        overrun <= 1'b1;
                    end
                    if (dec_done) begin
                        sync_skip  <= dec_code[2];
                        sync_data  <= dec_code[1];
                        sync_axis  <= dec_code[0];
                        sync_valid <= 1'b1;
                        dec_first  <= 1'b0;
                        if (!dec_code[2]) begin
                            sync_stamp <= cand_stamp;
                            ref_axis   <= dec_code[0];
                            state      <= ARMED;
                        end else begin
                            state <= prev_state;
                        end
                    end else if (dec_first) begin
                        rem       <= cand_w - DEC_THRESH;
                        code      <= 3'd0;
                        dec_first <= 1'b0;
                    end else begin
                        rem  <= rem - STEP_W;
                        code <= code + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
